lab2_proc_int_div_unit: RTL
===========================

LAB2_PROC_INT_DIV_UNIT -- requirements
Module: lab2_proc_int_div_unit

Interface
REQ-001 Parameter p_nbits, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_val  input  1  request valid.
REQ-005 req_rdy  output  1  unit can accept a request.
REQ-006 req_fn  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-007 req_a  input  32  dividend.
REQ-008 req_b  input  32  divisor.
REQ-009 resp_val  output  1  result valid.
REQ-010 resp_rdy  input  1  consumer accepts result.
REQ-011 resp_msg  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-012 The unit SHALL be a three-state FSM: IDLE, CALC and DONE.
REQ-013 In IDLE: req_rdy=1 and resp_val=0.
- On req_val&&req_rdy, capture fn/a/b, load a 6-bit iteration counter with 32, and go to CALC.
REQ-014 In CALC: req_rdy=0 and resp_val=0.
- Perform one restoring-division step per cycle on operand magnitudes.
- Decrement the counter each step; go to DONE after the 32nd step.
REQ-015 Latency: a request fired in cycle t SHALL give resp_val=1 first in cycle t+33, independent of operand values (no early termination).
REQ-016 In DONE: resp_val=1 and req_rdy=0.
- On resp_rdy=1, go to IDLE.
- While resp_rdy=0, stay in DONE with resp_msg held stable.
REQ-017 No same-cycle turnaround: the next request is accepted no earlier than the cycle after the response fires.
REQ-018 Input changes on req_a/req_b/req_fn outside the accept cycle SHALL NOT affect an in-flight result.
REQ-019 Unsigned ops: quotient = floor(a/b) and remainder = a - q*b, both modulo 2^32.
REQ-020 Signed ops (two's complement):
- Quotient truncates toward zero.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
REQ-021 Divide by zero:
- DIV and DIVU SHALL return 0xFFFFFFFF.
- REM and REMU SHALL return the unmodified dividend.
- Latency stays 33.
REQ-022 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-023 resp_msg SHALL be 0 in IDLE and CALC.

Reset
REQ-024 Asserting reset SHALL, without waiting for a clock edge, force:
- state=IDLE, counter=0, all datapath registers=0
- req_rdy=1, resp_val=0, resp_msg=0
REQ-025 Reset asserted mid-CALC or in DONE SHALL abort the operation and discard the result; no response is produced for it.
REQ-026 The first request SHALL be accepted on the first posedge after reset deasserts with req_val=1.

Structure
REQ-027 Shared package lab2_proc_div_pkg SHALL hold:
- the 2-bit fn encoding enum (DIV, DIVU, REM, REMU)
- the FSM state enum
- the width constant 32 and the iteration count 32
REQ-028 The top module SHALL contain the control FSM, counter and handshake logic.
REQ-029 Sub-module lab2_proc_int_div_dpath SHALL contain:
- remainder, quotient and divisor registers
- the 33-bit subtractor
- abs/negate logic
- special-case result muxing
REQ-030 Sign flags and fn SHALL be registered at accept time.

Verification
REQ-031 DIVU a=100, b=7 fired at cycle 0 -> resp_val first at cycle 33, resp_msg=14; REMU same operands -> 2.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIV a=7, b=0xFFFFFFFE -> 0xFFFFFFFD.
REQ-033 Divide by zero:
- DIVU a=5, b=0 -> 0xFFFFFFFF.
- REMU a=5, b=0 -> 5.
- DIV a=0xFFFFFFFB, b=0 -> 0xFFFFFFFF.
- REM a=0xFFFFFFFB, b=0 -> 0xFFFFFFFB.
REQ-034 Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-035 Backpressure: hold resp_rdy=0 for 10 cycles after resp_val rises -> resp_val=1 and resp_msg constant throughout, req_rdy=0; then resp_rdy=1 -> req_rdy=1 in the next cycle.
REQ-036 Reset after the 16th CALC cycle -> immediately req_rdy=1, resp_val=0, resp_msg=0; a new DIVU 81/9 after release -> 9 at accept+33.

Source files
------------

// File: rtl/lab2_proc_div_pkg.sv
// Shared types and constants for the iterative integer divider.
// Holds function encodings, FSM states and datapath sizing.
package lab2_proc_div_pkg;

  localparam int unsigned NBITS = 32;
  localparam int unsigned NITER = 32;

  typedef enum logic [1:0] {
    FN_DIV  = 2'd0,
    FN_DIVU = 2'd1,
    FN_REM  = 2'd2,
    FN_REMU = 2'd3
  } div_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/lab2_proc_int_div_dpath.sv
// Restoring-division datapath: operand magnitudes, one step per
// cycle, sign fix-up and divide-by-zero result selection.
import lab2_proc_div_pkg::*;

module lab2_proc_int_div_dpath (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             done,
  input  logic [1:0]       fn,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic [NBITS-1:0] resp_msg
);

  div_fn_e          fn_in;
  div_fn_e          fn_q;
  logic             is_signed;
  logic [NBITS-1:0] abs_a;
  logic [NBITS-1:0] abs_b;

  logic [NBITS-1:0] rem_q;
  logic [NBITS-1:0] quo_q;
  logic [NBITS-1:0] dvs_q;
  logic [NBITS-1:0] a_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             bz_q;

  logic [NBITS:0]   shifted;
  logic [NBITS:0]   diff;
  logic             ge;

  assign fn_in     = div_fn_e'(fn);
  assign is_signed = (fn_in == FN_DIV) || (fn_in == FN_REM);
  assign abs_a     = (is_signed && a[NBITS-1]) ? -a : a;
  assign abs_b     = (is_signed && b[NBITS-1]) ? -b : b;

  // Partial remainder is always below the divisor, so the
  // borrow out of the 33-bit subtract decides the quotient bit.
  assign shifted = {rem_q, quo_q[NBITS-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[NBITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      fn_q    <= FN_DIV;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bz_q    <= 1'b0;
    end else if (load) begin
      rem_q   <= '0;
      quo_q   <= abs_a;
      dvs_q   <= abs_b;
      a_q     <= a;
      fn_q    <= fn_in;
      neg_q_q <= is_signed && (a[NBITS-1] ^ b[NBITS-1]);
      neg_r_q <= is_signed && a[NBITS-1];
      bz_q    <= (b == '0);
    end else if (step) begin
      rem_q <= ge ? diff[NBITS-1:0] : shifted[NBITS-1:0];
      quo_q <= {quo_q[NBITS-2:0], ge};
    end
  end

  always_comb begin
    resp_msg = '0;
    if (done) begin
      unique case (fn_q)
        FN_DIV, FN_DIVU:
          resp_msg = bz_q    ? '1
                   : neg_q_q ? -quo_q
                   : quo_q;
        FN_REM, FN_REMU:
          resp_msg = bz_q    ? a_q
                   : neg_r_q ? -rem_q
                   : rem_q;
        default: resp_msg = '0;
      endcase
    end
  end

endmodule

// File: rtl/lab2_proc_int_div_unit.sv
// Iterative 32-bit divider: control FSM, step counter and
// valid/ready handshakes around the restoring datapath.
import lab2_proc_div_pkg::*;

module lab2_proc_int_div_unit #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [1:0]         req_fn,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_msg
);

  div_state_e state;
  logic [5:0] cnt;
  logic       load;
  logic       step;

  assign load = req_val && req_rdy;
  assign step = (state == ST_CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_val) begin
            state   <= ST_CALC;
            cnt     <= 6'(NITER);
            req_rdy <= 1'b0;
          end
        end
        ST_CALC: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state    <= ST_DONE;
            resp_val <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_rdy) begin
            state    <= ST_IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

  lab2_proc_int_div_dpath u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .done     (resp_val),
    .fn       (req_fn),
    .a        (req_a),
    .b        (req_b),
    .resp_msg (resp_msg)
  );

endmodule
